dogx_output_receiver: RTL and testbench
=======================================

// Module: dogx_output_receiver
// PURPOSE
//  Receive end of the DOGX converter output link. Samples the 11-bit converter_output bus against the
//  forwarded 3 MHz clock. Rebuilds HSNR/HDR sample pairs (mode 0) or packs the 1-bit NS stream into words (mode 1).
//  Buffers results in a small FIFO with valid/ready toward the downstream consumer.
// PARAMETERS
//  SAMPLE_DELAY  2    CLK_24M cycles from a detected clock_3M_in edge to data capture (1..3)
//  WORD_BITS     16   mode-1 packed word width (1..18)
//  FIFO_DEPTH    4    output FIFO entries (power of 2, >=2)
//  TIMEOUT       32   CLK_24M cycles without a clock_3M_in edge before link declared lost
// PORTS
//  CLK_24M           in   1   system clock, 24 MHz
//  reset             in   1   synchronous, active-high
//  converter_output  in   11  link data bus
//  clock_3M_in       in   1   forwarded 3 MHz link clock, same-domain level
//  operation_mode    in   1   0 = 11-bit interleaved HSNR/HDR, 1 = 1-bit stream in LSB
//  out_data          out  18  mode0 {HSNR[8:0],HDR[8:0]}; mode1 {zero pad, word[WORD_BITS-1:0]}
//  out_mode          out  1   mode tag of the entry at FIFO head
//  out_valid         out  1   FIFO not empty
//  out_ready         in   1   consumer accepts head when out_valid & out_ready
//  fifo_level        out  $clog2(FIFO_DEPTH)+1  current occupancy
//  overflow          out  1   sticky: an entry was dropped because FIFO was full
//  clear_overflow    in   1   clears overflow and drop_count (1-cycle pulse)
//  drop_count        out  8   dropped entries, saturates at 255
//  link_active       out  1   1 while clock_3M_in edges keep arriving within TIMEOUT
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, partial state cleared, edge detector primed with current clock_3M_in.
//  Edge detect: clk_q <= clock_3M_in; rise = clock_3M_in & ~clk_q, fall = ~clock_3M_in & clk_q.
//  Capture strobe fires exactly SAMPLE_DELAY cycles after rise/fall; a new edge restarts the delay counter.
//  Mode 0: word during clock_3M_in high = HDR, low = HSNR.
//   fall-capture: HSNR = converter_output[8:0], pend_hsnr <= 1.
//   rise-capture: HDR = converter_output[10:2]; push {HSNR,HDR} if pend_hsnr, clear pend_hsnr.
//   HDR without pending HSNR is discarded (start-up alignment); first pair always HSNR-then-HDR.
//  Mode 1: rise-capture only; bit = converter_output[0]; shifted in MSB-first, bit_cnt++.
//   At bit_cnt==WORD_BITS: push word, bit_cnt <= 0, same cycle.
//  Push latency: entry visible on out_valid the cycle after its capture strobe.
//  FIFO: push and pop in the same cycle allowed at any level (level unchanged when full + pop: push succeeds).
//   Push when full without pop: entry dropped, overflow <= 1, drop_count++ (sat).
//   clear_overflow coincident with a drop: drop wins (overflow=1, drop_count=1).
//  operation_mode change (detected vs. registered copy): pend_hsnr, bit_cnt, shift reg cleared that cycle.
//   FIFO contents kept, each entry retains its out_mode tag.
//  Link timeout: idle counter resets on any edge. At TIMEOUT it sets link_active=0 and clears partial state.
//   No pushes while link_active=0. link_active returns to 1 on the next edge.
//  Reset mid-frame: partial word/pair discarded, FIFO flushed, counters zeroed next cycle.
// CONFIGURATION
//  RX_FORMAT_CHECK_EN defined: adds output format_error (1 bit, sticky, cleared by clear_overflow).
//   Mode 0: set if HSNR word bits [10:9] != {2{[8]}}, or HDR word bits [1:0] != 2'b00.
//   Mode 1: set if converter_output[10:1] != 0 at capture. Offending entries are still pushed.
//  Not defined: no format_error port, no check logic; capture/pack behaviour identical.
// TESTING
//  Mode0, HSNR=11'h7FF (-1), HDR=11'h004 -> one entry out_data=18'h3FE01, out_mode=0.
//  Mode0 stream starting in HDR half -> first HDR dropped; first entry pairs next HSNR with following HDR.
//  Mode1, 16 bits 1010...10 -> out_data=18'h0AAAA after 16th rise-capture; bit_cnt back to 0.
//  out_ready=0, 5 mode0 pairs, FIFO_DEPTH=4 -> fifo_level=4, overflow=1, drop_count=1; clear_overflow -> 0.
//  Stop clock_3M_in 32 cycles mid-word -> link_active=0, partial word lost, no push.
//   Restart -> link_active=1, fresh word.
//  RX_FORMAT_CHECK_EN: mode0 HDR word 11'h001 -> format_error=1, entry pushed; without macro port absent.

Source files
------------

// File: rtl/dogx_output_receiver.sv
// DOGX link receiver: samples the converter bus against the forwarded 3 MHz clock, rebuilds HSNR/HDR pairs
// or packed 1-bit words, and queues them in a valid/ready FIFO. Optional RX_FORMAT_CHECK_EN adds format_error.
module dogx_output_receiver #(
  parameter int SAMPLE_DELAY = 2,
  parameter int WORD_BITS    = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT      = 32
) (
  input  logic                          CLK_24M,
  input  logic                          reset,
  input  logic [10:0]                   converter_output,
  input  logic                          clock_3M_in,
  input  logic                          operation_mode,
  output logic [17:0]                   out_data,
  output logic                          out_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clear_overflow,
  output logic [7:0]                    drop_count,
  output logic                          link_active
`ifdef RX_FORMAT_CHECK_EN
  ,
  output logic                          format_error
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(WORD_BITS + 1);

  logic                 clk_q;
  logic                 mode_q;
  logic                 rise;
  logic                 fall;
  logic                 clk_edge;
  logic [1:0]           dly_cnt;
  logic                 cap_rise;
  logic                 strobe;
  logic [IW-1:0]        idle_cnt;
  logic                 timeout_hit;
  logic                 mode_chg;
  logic                 cap_ok;

  logic                 pend_hsnr;
  logic [8:0]           hsnr;
  logic [WORD_BITS-1:0] shift_reg;
  logic [WORD_BITS-1:0] next_word;
  logic [BW-1:0]        bit_cnt;
  logic                 word_done;

  logic                 push;
  logic [17:0]          push_data;
  logic                 pop;
  logic                 full;
  logic                 do_push;
  logic                 drop;
  logic [18:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        count;

  assign rise        = clock_3M_in & ~clk_q;
  assign fall        = ~clock_3M_in & clk_q;
  assign clk_edge    = rise | fall;
  assign strobe      = (dly_cnt == 2'd1);
  assign timeout_hit = (idle_cnt == IW'(1)) & ~clk_edge;
  assign mode_chg    = operation_mode != mode_q;
  assign cap_ok      = strobe & link_active & ~mode_chg & ~timeout_hit;
  assign next_word   = WORD_BITS'({shift_reg, converter_output[0]});
  assign word_done   = (bit_cnt == BW'(WORD_BITS - 1));

  // Edge detect, capture delay and link watchdog; a new edge always restarts both timers.
  always_ff @(posedge CLK_24M) begin
    if (reset) begin
      clk_q       <= clock_3M_in;
      mode_q      <= operation_mode;
      dly_cnt     <= '0;
      cap_rise    <= 1'b0;
      idle_cnt    <= '0;
      link_active <= 1'b0;
    end else begin
      clk_q  <= clock_3M_in;
      mode_q <= operation_mode;
      if (clk_edge) begin
        dly_cnt     <= 2'(SAMPLE_DELAY);
        cap_rise    <= rise;
        idle_cnt    <= IW'(TIMEOUT);
        link_active <= 1'b1;
      end else if (timeout_hit) begin
        dly_cnt     <= '0;
        idle_cnt    <= '0;
        link_active <= 1'b0;
      end else begin
        if (dly_cnt != 2'd0) dly_cnt <= dly_cnt - 2'd1;
        if (idle_cnt != '0) idle_cnt <= idle_cnt - IW'(1);
      end
    end
  end

  always_comb begin
    push      = 1'b0;
    push_data = '0;
    if (cap_ok && cap_rise) begin
      if (!operation_mode) begin
        push      = pend_hsnr;
        push_data = {hsnr, converter_output[10:2]};
      end else begin
        push      = word_done;
        push_data = 18'(next_word);
      end
    end
  end

  always_ff @(posedge CLK_24M) begin
    if (reset || mode_chg || timeout_hit) begin
      pend_hsnr <= 1'b0;
      hsnr      <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (cap_ok) begin
      if (!operation_mode) begin
        if (cap_rise) begin
          pend_hsnr <= 1'b0;
        end else begin
          hsnr      <= converter_output[8:0];
          pend_hsnr <= 1'b1;
        end
      end else if (cap_rise) begin
        shift_reg <= next_word;
        bit_cnt   <= word_done ? '0 : bit_cnt + BW'(1);
      end
    end
  end

  // Full FIFO with a simultaneous pop still accepts the push; the head slot is freed this cycle.
  assign pop     = out_valid & out_ready;
  assign full    = (count == LW'(FIFO_DEPTH));
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge CLK_24M) begin
    if (do_push) mem[wr_ptr] <= {operation_mode, push_data};
  end

  always_ff @(posedge CLK_24M) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? mem[rd_ptr][17:0] : '0;
  assign out_mode   = out_valid ? mem[rd_ptr][18] : 1'b0;
  assign fifo_level = count;

  always_ff @(posedge CLK_24M) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= clear_overflow ? 8'd1 : (drop_count != 8'hFF) ? drop_count + 8'd1 : drop_count;
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

`ifdef RX_FORMAT_CHECK_EN
  logic fmt_bad;

  always_comb begin
    fmt_bad = 1'b0;
    if (cap_ok) begin
      if (!operation_mode)
        fmt_bad = cap_rise ? (converter_output[1:0] != 2'b00)
                           : (converter_output[10:9] != {2{converter_output[8]}});
      else if (cap_rise)
        fmt_bad = (converter_output[10:1] != 10'd0);
    end
  end

  always_ff @(posedge CLK_24M) begin
    if (reset)               format_error <= 1'b0;
    else if (fmt_bad)        format_error <= 1'b1;
    else if (clear_overflow) format_error <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_dogx_output_receiver.sv
// Directed bench for dogx_output_receiver: pairing, packing, FIFO overflow, link timeout, reset, format check.
module tb_dogx_output_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] converter_output;
  logic        clock_3M_in;
  logic        operation_mode;
  logic [17:0] out_data;
  logic        out_mode;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        clear_overflow;
  logic [7:0]  drop_count;
  logic        link_active;
`ifdef RX_FORMAT_CHECK_EN
  logic        format_error;
`endif

  int total = 0;
  int bad   = 0;

  dogx_output_receiver dut (
    .CLK_24M          (clk),
    .reset            (reset),
    .converter_output (converter_output),
    .clock_3M_in      (clock_3M_in),
    .operation_mode   (operation_mode),
    .out_data         (out_data),
    .out_mode         (out_mode),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .fifo_level       (fifo_level),
    .overflow         (overflow),
    .clear_overflow   (clear_overflow),
    .drop_count       (drop_count),
    .link_active      (link_active)
`ifdef RX_FORMAT_CHECK_EN
    ,
    .format_error     (format_error)
`endif
  );

  always #5 clk = ~clk;

  // One half period of the 3 MHz link clock: 4 system cycles at a fixed level and data word.
  task automatic half(input logic lvl, input logic [10:0] d);
    @(posedge clk); #1;
    clock_3M_in      = lvl;
    converter_output = d;
    repeat (3) @(posedge clk);
  endtask

  task automatic pair(input logic [10:0] hs, input logic [10:0] hd);
    half(1'b0, hs);
    half(1'b1, hd);
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 15; i > 15 - n; i--) begin
      half(1'b0, 11'h000);
      half(1'b1, {10'd0, w[i]});
    end
  endtask

  task automatic set_mode(input logic m);
    @(posedge clk); #1;
    operation_mode = m;
  endtask

  task automatic pop_one;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic pulse_clear;
    @(posedge clk); #1;
    clear_overflow = 1'b1;
    @(posedge clk); #1;
    clear_overflow = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; converter_output = '0; clock_3M_in = 1'b0; operation_mode = 1'b0;
    out_ready = 1'b0; clear_overflow = 1'b0;
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    total++; if (out_data !== 18'h0) begin bad++; $display("FAIL reset_data got %h want 0", out_data); end
    total++; if ({overflow, drop_count} !== 9'h0) begin bad++; $display("FAIL reset_ovf got %b/%0d want 0/0", overflow, drop_count); end
    total++; if (link_active !== 1'b0) begin bad++; $display("FAIL reset_link got %b want 0", link_active); end
  endtask

  task automatic test_mode0_pair;
    half(1'b1, 11'h154);          // HDR half first: no pending HSNR, must be discarded
    pair(11'h7FF, 11'h004);
    @(negedge clk);
    total++; if (link_active !== 1'b1) begin bad++; $display("FAIL m0_link got %b want 1", link_active); end
    total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL m0_level got %0d want 1", fifo_level); end
    total++; if (out_data !== 18'h3FE01) begin bad++; $display("FAIL m0_data got %h want 3fe01", out_data); end
    total++; if (out_mode !== 1'b0) begin bad++; $display("FAIL m0_mode got %b want 0", out_mode); end
    pop_one;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL m0_pop got %b want 0", out_valid); end
  endtask

  task automatic test_mode1_word;
    set_mode(1'b1);
    send_bits(16'hAAAA, 15);
    @(negedge clk);
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL m1_early got %0d want 0", fifo_level); end
    half(1'b0, 11'h000);
    half(1'b1, 11'h000);
    @(negedge clk);
    total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL m1_level got %0d want 1", fifo_level); end
    total++; if (out_data !== 18'h0AAAA) begin bad++; $display("FAIL m1_data got %h want 0aaaa", out_data); end
    total++; if (out_mode !== 1'b1) begin bad++; $display("FAIL m1_mode got %b want 1", out_mode); end
    pop_one;
  endtask

  task automatic test_mode_tag;
    set_mode(1'b0);
    pair(11'h003, 11'h00C);
    set_mode(1'b1);
    send_bits(16'hFFFF, 16);
    @(negedge clk);
    total++; if (fifo_level !== 3'd2) begin bad++; $display("FAIL tag_level got %0d want 2", fifo_level); end
    total++; if ({out_mode, out_data} !== {1'b0, 18'h00603}) begin bad++; $display("FAIL tag_head0 got %b/%h want 0/00603", out_mode, out_data); end
    pop_one;
    @(negedge clk);
    total++; if ({out_mode, out_data} !== {1'b1, 18'h0FFFF}) begin bad++; $display("FAIL tag_head1 got %b/%h want 1/0ffff", out_mode, out_data); end
    pop_one;
  endtask

  task automatic test_overflow;
    logic [17:0] exp;
    set_mode(1'b0);
    for (int i = 0; i < 5; i++) pair(11'(i + 1), 11'((i + 1) << 2));
    @(negedge clk);
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL ovf_level got %0d want 4", fifo_level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got %b want 1", overflow); end
    total++; if (drop_count !== 8'd1) begin bad++; $display("FAIL ovf_count got %0d want 1", drop_count); end
    pulse_clear;
    @(negedge clk);
    total++; if ({overflow, drop_count} !== 9'h0) begin bad++; $display("FAIL ovf_clear got %b/%0d want 0/0", overflow, drop_count); end
    for (int i = 0; i < 4; i++) begin
      exp = {9'(i + 1), 9'(i + 1)};
      @(negedge clk);
      total++; if (out_data !== exp) begin bad++; $display("FAIL ovf_drain%0d got %h want %h", i, out_data, exp); end
      pop_one;
    end
    @(negedge clk);
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL ovf_empty got %0d want 0", fifo_level); end
  endtask

  task automatic test_timeout;
    set_mode(1'b1);
    send_bits(16'hF800, 5);
    @(negedge clk);
    total++; if (link_active !== 1'b1) begin bad++; $display("FAIL to_before got %b want 1", link_active); end
    repeat (40) @(posedge clk);
    @(negedge clk);
    total++; if (link_active !== 1'b0) begin bad++; $display("FAIL to_lost got %b want 0", link_active); end
    send_bits(16'hC3A5, 11);
    @(negedge clk);
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL to_partial got %0d want 0", fifo_level); end
    total++; if (link_active !== 1'b1) begin bad++; $display("FAIL to_back got %b want 1", link_active); end
    for (int i = 4; i >= 0; i--) begin
      half(1'b0, 11'h000);
      half(1'b1, {10'd0, 1'((16'hC3A5 >> i) & 16'h1)});
    end
    @(negedge clk);
    total++; if ({fifo_level, out_data} !== {3'd1, 18'h0C3A5}) begin bad++; $display("FAIL to_word got %0d/%h want 1/0c3a5", fifo_level, out_data); end
    pop_one;
  endtask

  task automatic test_reset_mid;
    set_mode(1'b0);
    pair(11'h001, 11'h004);
    half(1'b0, 11'h0AA);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    total++; if ({out_valid, fifo_level} !== 4'h0) begin bad++; $display("FAIL rst_flush got %b/%0d want 0/0", out_valid, fifo_level); end
    half(1'b1, 11'h008);
    @(negedge clk);
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rst_pend got %0d want 0", fifo_level); end
  endtask

`ifdef RX_FORMAT_CHECK_EN
  task automatic test_format;
    pulse_clear;
    @(negedge clk);
    total++; if (format_error !== 1'b0) begin bad++; $display("FAIL fmt_clear got %b want 0", format_error); end
    pair(11'h000, 11'h001);
    @(negedge clk);
    total++; if (format_error !== 1'b1) begin bad++; $display("FAIL fmt_set got %b want 1", format_error); end
    total++; if ({fifo_level, out_data} !== {3'd1, 18'h00000}) begin bad++; $display("FAIL fmt_push got %0d/%h want 1/00000", fifo_level, out_data); end
    pop_one;
  endtask
`endif

  initial begin
    test_reset;
    test_mode0_pair;
    test_mode1_word;
    test_mode_tag;
    test_overflow;
    test_timeout;
    test_reset_mid;
`ifdef RX_FORMAT_CHECK_EN
    test_format;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
